// File: rtl/hyperbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_arbiter
//  Purpose  : Two-port round-robin arbiter in front of one HyperBus controller
//             request interface. Each port has a single-entry pending register.
//             One transaction is in flight downstream at a time. Completions
//             and read data are routed back to the granted port. A watchdog
//             aborts transactions whose completion never arrives.
//  Ports    : hbus_clk/hbus_rst      clock, synchronous active-high reset
//             mN_adr_i/dat_i/mask_i  request address, write data and mask
//             mN_rrq/mN_wrq          single-cycle read/write request pulses
//             mN_dat_o               read data, held until the next read
//             mN_ready/valid/err     write-ack, read-valid and abort pulses
//             mN_busy                port has a pending or in-flight request
//             hbus_adr_o/dat_o/mask_o, hbus_rrq/wrq   controller request side
//             hbus_dat_i, hbus_ready/valid/busy       controller response side
//  Revision : 1.0  initial release
// ============================================================================
module hyperbus_arbiter #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TIMEOUT         = 1024
) (
  input  logic                         hbus_clk,
  input  logic                         hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [HBUS_DATA_WIDTH/8-1:0] m0_mask_i,
  input  logic                         m0_rrq,
  input  logic                         m0_wrq,
  output logic [HBUS_DATA_WIDTH-1:0]   m0_dat_o,
  output logic                         m0_ready,
  output logic                         m0_valid,
  output logic                         m0_err,
  output logic                         m0_busy,
  input  logic [HBUS_ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [HBUS_DATA_WIDTH/8-1:0] m1_mask_i,
  input  logic                         m1_rrq,
  input  logic                         m1_wrq,
  output logic [HBUS_DATA_WIDTH-1:0]   m1_dat_o,
  output logic                         m1_ready,
  output logic                         m1_valid,
  output logic                         m1_err,
  output logic                         m1_busy,
  output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_o,
  output logic                         hbus_rrq,
  output logic                         hbus_wrq,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic                         hbus_ready,
  input  logic                         hbus_valid,
  input  logic                         hbus_busy
);

  localparam int          MASK_WIDTH = HBUS_DATA_WIDTH / 8;
  localparam logic [15:0] WD_LOAD    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_d;
  logic   grant, grant_d;
  logic   last;
  logic   issue_we;
  logic [15:0] wd;

  logic [1:0] pend_v, pend_v_d;
  logic [1:0] pend_we;
  logic [HBUS_ADDR_WIDTH-1:0] pend_adr  [2];
  logic [HBUS_DATA_WIDTH-1:0] pend_dat  [2];
  logic [MASK_WIDTH-1:0]      pend_mask [2];

  logic [1:0] busy, busy_d;
  logic [1:0] ready_q, valid_q, err_q;
  logic [HBUS_DATA_WIDTH-1:0] dat_q [2];

  logic [1:0] accept;
  logic       start, complete, abort;

  // A request is taken only while the port is idle; otherwise it is dropped.
  assign accept = {m1_rrq | m1_wrq, m0_rrq | m0_wrq} & ~busy;

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    start    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if ((pend_v != 2'b00) && !hbus_busy) begin
          state_d = ISSUE;
          start   = 1'b1;
          // On a tie the port that was not served last wins.
          grant_d = (pend_v == 2'b11) ? ~last : pend_v[1];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion is checked first so it wins over a same-cycle expiry.
        if (issue_we ? hbus_ready : hbus_valid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (wd == 16'd1) begin
          // Expiry one cycle before zero so err lands TIMEOUT cycles after
          // the downstream request pulse.
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pend_v_d = pend_v;
    busy_d   = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (accept[n]) begin
        pend_v_d[n] = 1'b1;
      end else if (start && (grant_d == 1'(n))) begin
        pend_v_d[n] = 1'b0;
      end
      busy_d[n] = pend_v_d[n] | ((state_d != IDLE) && (grant_d == 1'(n)));
    end
  end

  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last        <= 1'b1;
      issue_we    <= 1'b0;
      wd          <= '0;
      pend_v      <= '0;
      pend_we     <= '0;
      busy        <= '0;
      ready_q     <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      hbus_adr_o  <= '0;
      hbus_dat_o  <= '0;
      hbus_mask_o <= '0;
      hbus_rrq    <= 1'b0;
      hbus_wrq    <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        pend_adr[n]  <= '0;
        pend_dat[n]  <= '0;
        pend_mask[n] <= '0;
        dat_q[n]     <= '0;
      end
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      pend_v   <= pend_v_d;
      busy     <= busy_d;
      hbus_rrq <= 1'b0;
      hbus_wrq <= 1'b0;
      ready_q  <= '0;
      valid_q  <= '0;
      err_q    <= '0;

      // Simultaneous rrq and wrq resolve to a write.
      if (accept[0]) begin
        pend_we[0]  <= m0_wrq;
        pend_adr[0] <= m0_adr_i;
        if (m0_wrq) begin
          pend_dat[0]  <= m0_dat_i;
          pend_mask[0] <= m0_mask_i;
        end
      end
      if (accept[1]) begin
        pend_we[1]  <= m1_wrq;
        pend_adr[1] <= m1_adr_i;
        if (m1_wrq) begin
          pend_dat[1]  <= m1_dat_i;
          pend_mask[1] <= m1_mask_i;
        end
      end

      if (start) begin
        hbus_adr_o  <= pend_adr[grant_d];
        hbus_dat_o  <= pend_dat[grant_d];
        hbus_mask_o <= pend_mask[grant_d];
        issue_we    <= pend_we[grant_d];
        hbus_wrq    <= pend_we[grant_d];
        hbus_rrq    <= ~pend_we[grant_d];
      end

      if (state == ISSUE) begin
        wd <= WD_LOAD;
      end else if (state == WAIT) begin
        wd <= wd - 16'd1;
      end

      if (complete) begin
        last <= grant;
        if (issue_we) begin
          ready_q[grant] <= 1'b1;
        end else begin
          valid_q[grant] <= 1'b1;
          dat_q[grant]   <= hbus_dat_i;
        end
      end
      if (abort) begin
        last         <= grant;
        err_q[grant] <= 1'b1;
      end
    end
  end

  assign m0_dat_o = dat_q[0];
  assign m1_dat_o = dat_q[1];
  assign m0_ready = ready_q[0];
  assign m1_ready = ready_q[1];
  assign m0_valid = valid_q[0];
  assign m1_valid = valid_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_busy  = busy[0];
  assign m1_busy  = busy[1];

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyperbus_arbiter
//  Purpose  : Directed self-checking bench for hyperbus_arbiter (TIMEOUT=8).
//             Downstream requests and upstream responses are predicted into
//             queues when stimulus is driven and popped when the DUT emits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hyperbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int MW = DW / 8;

  logic hbus_clk = 1'b0;
  logic hbus_rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, hbus_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, hbus_dat_o, hbus_dat_i;
  logic [MW-1:0] m0_mask_i, m1_mask_i, hbus_mask_o;
  logic m0_rrq, m0_wrq, m0_ready, m0_valid, m0_err, m0_busy;
  logic m1_rrq, m1_wrq, m1_ready, m1_valid, m1_err, m1_busy;
  logic hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

  always #5 hbus_clk = ~hbus_clk;

  hyperbus_arbiter #(.HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_mask_i(m0_mask_i),
    .m0_rrq(m0_rrq), .m0_wrq(m0_wrq), .m0_dat_o(m0_dat_o), .m0_ready(m0_ready),
    .m0_valid(m0_valid), .m0_err(m0_err), .m0_busy(m0_busy),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_mask_i(m1_mask_i),
    .m1_rrq(m1_rrq), .m1_wrq(m1_wrq), .m1_dat_o(m1_dat_o), .m1_ready(m1_ready),
    .m1_valid(m1_valid), .m1_err(m1_err), .m1_busy(m1_busy),
    .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_mask_o(hbus_mask_o),
    .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_dat_i(hbus_dat_i),
    .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [MW-1:0] mask;
  } dn_t;

  typedef struct {
    int            port;
    logic [2:0]    kind;   // {ready, valid, err}
    logic [DW-1:0] dat;
  } up_t;

  dn_t dn_q[$];
  up_t up_q[$];
  int  nvec = 0;
  int  nerr = 0;
  logic saw_dn = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_up(input int p, input logic rdy, input logic vld, input logic er,
                          input logic [DW-1:0] dat);
    up_t e;
    if (rdy | vld | er) begin
      chk($sformatf("up%0d_expected", p), 64'(up_q.size() != 0), 64'd1);
      if (up_q.size() != 0) begin
        e = up_q.pop_front();
        chk($sformatf("up%0d_port", p), 64'(p), 64'(e.port));
        chk($sformatf("up%0d_kind", p), {rdy, vld, er}, e.kind);
        if (vld) chk($sformatf("up%0d_rdata", p), dat, e.dat);
      end
    end
  endtask

  // One clock: clear single-cycle pulses, then check anything the DUT emitted.
  task automatic cyc();
    dn_t e;
    @(posedge hbus_clk);
    #1;
    m0_rrq = 1'b0; m0_wrq = 1'b0; m1_rrq = 1'b0; m1_wrq = 1'b0;
    hbus_ready = 1'b0; hbus_valid = 1'b0;
    saw_dn = hbus_rrq | hbus_wrq;
    if (saw_dn) begin
      chk("dn_expected", 64'(dn_q.size() != 0), 64'd1);
      if (dn_q.size() != 0) begin
        e = dn_q.pop_front();
        chk("dn_kind", {hbus_wrq, hbus_rrq}, {e.we, ~e.we});
        chk("dn_adr", hbus_adr_o, e.adr);
        if (e.we) begin
          chk("dn_wdata", hbus_dat_o, e.dat);
          chk("dn_mask", hbus_mask_o, e.mask);
        end
      end
    end
    check_up(0, m0_ready, m0_valid, m0_err, m0_dat_o);
    check_up(1, m1_ready, m1_valid, m1_err, m1_dat_o);
  endtask

  task automatic drive(input int p, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [MW-1:0] mask);
    if (p == 0) begin
      m0_adr_i = adr; m0_dat_i = dat; m0_mask_i = mask; m0_wrq = we; m0_rrq = ~we;
    end else begin
      m1_adr_i = adr; m1_dat_i = dat; m1_mask_i = mask; m1_wrq = we; m1_rrq = ~we;
    end
  endtask

  task automatic push_dn(input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [MW-1:0] mask);
    dn_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.mask = mask;
    dn_q.push_back(e);
  endtask

  task automatic req(input int p, input logic we, input logic [AW-1:0] adr,
                     input logic [DW-1:0] dat, input logic [MW-1:0] mask);
    drive(p, we, adr, dat, mask);
    push_dn(we, adr, dat, mask);
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!saw_dn && n < 40);
    chk(tag, 64'(saw_dn), 64'd1);
  endtask

  // Called in the cycle of the downstream pulse; completes `delay` cycles later.
  task automatic respond(input int p, input bit rd, input logic [DW-1:0] dat, input int delay);
    up_t e;
    logic pulse;
    repeat (delay) cyc();
    if (rd) hbus_valid = 1'b1; else hbus_ready = 1'b1;
    hbus_dat_i = dat;
    e.port = p; e.kind = rd ? 3'b010 : 3'b100; e.dat = dat;
    up_q.push_back(e);
    cyc();
    pulse = rd ? ((p == 0) ? m0_valid : m1_valid) : ((p == 0) ? m0_ready : m1_ready);
    chk("resp_latency", 64'(pulse), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {m1_busy, m0_busy}, 2'b00);
    chk({tag, "_pulses"}, {m0_ready, m0_valid, m0_err, m1_ready, m1_valid, m1_err,
                           hbus_rrq, hbus_wrq}, 8'h00);
    chk({tag, "_hbus_adr"}, hbus_adr_o, 32'h0);
    chk({tag, "_hbus_dat"}, {hbus_dat_o, 6'h0, hbus_mask_o}, 24'h0);
    chk({tag, "_mdat"}, {m0_dat_o, m1_dat_o}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    hbus_rst = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_mask_i = '0; m0_rrq = 1'b0; m0_wrq = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_mask_i = '0; m1_rrq = 1'b0; m1_wrq = 1'b0;
    hbus_dat_i = '0; hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;
    cyc();
    cyc();
    chk_reset_outputs("reset");
    hbus_rst = 1'b0;

    // 1. Single write, with a stray hbus_valid that must be ignored.
    req(0, 1'b1, 32'h100, 16'hBEEF, 2'b00);
    cyc();
    chk("t1_busy_c1", 64'(m0_busy), 64'd1);
    chk("t1_no_wrq_c1", 64'(hbus_wrq), 64'd0);
    cyc();
    chk("t1_wrq_c2", 64'(saw_dn), 64'd1);
    cyc();
    cyc();
    hbus_valid = 1'b1;
    respond(0, 1'b0, 16'h0000, 3);
    chk("t1_busy_done", 64'(m0_busy), 64'd0);

    // 2. Single read on port 1; port 0 untouched.
    req(1, 1'b0, 32'h200, 16'h0, 2'b00);
    wait_issue("t2_issue");
    respond(1, 1'b1, 16'h1234, 4);
    chk("t2_m1_dat", m1_dat_o, 16'h1234);
    chk("t2_m0_dat", m0_dat_o, 16'h0000);
    chk("t2_m0_busy", 64'(m0_busy), 64'd0);

    // 3. Round-robin: simultaneous reads alternate 0,1,0,1,...
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b0, 32'h300 + 32'(i * 16), 16'h0, 2'b00);
      req(1, 1'b0, 32'h400 + 32'(i * 16), 16'h0, 2'b00);
      wait_issue("t3_issue0");
      respond(0, 1'b1, 16'h1000 + 16'(i), 2);
      wait_issue("t3_issue1");
      respond(1, 1'b1, 16'h2000 + 16'(i), 2);
    end

    // 4. Controller busy gating and ignored second request.
    hbus_busy = 1'b1;
    req(0, 1'b0, 32'h500, 16'h0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_held_rrq", 64'(hbus_rrq), 64'd0);
      if (i == 3) begin
        chk("t4_m0_busy", 64'(m0_busy), 64'd1);
        drive(0, 1'b1, 32'hDEAD, 16'hDEAD, 2'b11);
      end
    end
    hbus_busy = 1'b0;
    cyc();
    chk("t4_release_rrq", 64'(saw_dn), 64'd1);
    respond(0, 1'b1, 16'h4444, 3);
    repeat (4) cyc();

    // 5. Watchdog abort on port 1, then pending port 0 is granted.
    req(1, 1'b0, 32'h600, 16'h0, 2'b00);
    cyc();
    req(0, 1'b0, 32'h610, 16'h0, 2'b00);
    wait_issue("t5_issue1");
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("t5_no_early_err", 64'(m1_err), 64'd0);
    end
    begin
      up_t e;
      e.port = 1; e.kind = 3'b001; e.dat = '0;
      up_q.push_back(e);
    end
    cyc();
    chk("t5_err_at_T", 64'(m1_err), 64'd1);
    chk("t5_dat_hold", m1_dat_o, 16'h2003);
    hbus_valid = 1'b1;
    hbus_dat_i = 16'hBAD1;
    cyc();
    chk("t5_next_grant", 64'(saw_dn), 64'd1);
    chk("t5_late_valid", {m0_valid, m1_valid}, 2'b00);
    respond(0, 1'b1, 16'h5555, 3);
    // Completion in the expiry cycle wins.
    req(1, 1'b0, 32'h620, 16'h0, 2'b00);
    wait_issue("t5_issue_tie");
    respond(1, 1'b1, 16'h7777, 7);
    chk("t5_tie_no_err", 64'(m1_err), 64'd0);

    // 6a. Reset during WAIT drops in-flight and pending work.
    req(0, 1'b1, 32'h700, 16'hA5A5, 2'b01);
    wait_issue("t6_issue");
    cyc();
    drive(1, 1'b0, 32'h710, 16'h0, 2'b00);
    cyc();
    chk("t6_m1_pending", 64'(m1_busy), 64'd1);
    hbus_rst = 1'b1;
    hbus_ready = 1'b1;
    cyc();
    hbus_rst = 1'b0;
    chk_reset_outputs("t6_rst");
    repeat (8) cyc();

    // 6b. rrq and wrq together issue a write.
    m0_adr_i = 32'h800; m0_dat_i = 16'h1357; m0_mask_i = 2'b10;
    m0_rrq = 1'b1; m0_wrq = 1'b1;
    push_dn(1'b1, 32'h800, 16'h1357, 2'b10);
    wait_issue("t6b_issue");
    chk("t6b_no_rrq", 64'(hbus_rrq), 64'd0);
    respond(0, 1'b0, 16'h0, 2);
    repeat (3) cyc();

    chk("end_dn_empty", 64'(dn_q.size()), 64'd0);
    chk("end_up_empty", 64'(up_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
